// File: rtl/udma_ethernet_rx_ring.sv
// RX frame packer and 4-slot descriptor ring sequencer for the uDMA Ethernet.
// Packs MAC bytes into little-endian words and commits good frames to the ring.
module udma_ethernet_rx_ring #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int MAX_BYTES      = 1536
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [L2_AWIDTH_NOAL-1:0] startaddr0_i,
    input  logic [L2_AWIDTH_NOAL-1:0] startaddr1_i,
    input  logic [L2_AWIDTH_NOAL-1:0] startaddr2_i,
    input  logic [L2_AWIDTH_NOAL-1:0] startaddr3_i,
    input  logic [3:0]                desc_busy_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    input  logic                      rx_last_i,
    input  logic                      rx_err_i,
    output logic                      rx_ready_o,
    output logic [31:0]               data_o,
    output logic [L2_AWIDTH_NOAL-1:0] addr_o,
    output logic                      data_valid_o,
    input  logic                      data_ready_i,
    output logic [1:0]                rx_pointer_o,
    output logic [TRANS_SIZE-1:0]     rx_size_o,
    output logic                      frame_irq_o,
    output logic                      drop_o,
    output logic                      trunc_o
);

    localparam logic [TRANS_SIZE-1:0] MaxCnt = TRANS_SIZE'(MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DROP,
        DROP_END,
        FLUSH,
        COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [1:0]                slot_q;
    logic [1:0]                slot_nxt;
    logic [1:0]                cur_slot;
    logic [TRANS_SIZE-1:0]     cnt_q;
    logic [31:0]               wbuf_q;
    logic [31:0]               wnext;
    logic                      trunc_q;
    logic                      acc;
    logic                      start_ok;
    logic                      store;
    logic                      emit;
    logic [1:0]                lane;
    logic [L2_AWIDTH_NOAL-1:0] base;
    logic [L2_AWIDTH_NOAL-1:0] off;

    assign slot_nxt = rx_pointer_o + 2'd1;
    // The first byte is handled in IDLE, before slot_q has been captured.
    assign cur_slot = (state_q == IDLE) ? slot_nxt : slot_q;
    assign start_ok = en_i & ~desc_busy_i[slot_nxt];

    assign rx_ready_o = ((state_q == IDLE) | (state_q == RECV) | (state_q == DROP))
                      & ~(data_valid_o & ~data_ready_i);
    assign acc = rx_valid_i & rx_ready_o;

    assign store = acc & (((state_q == RECV) & (cnt_q < MaxCnt))
                        | ((state_q == IDLE) & start_ok));
    assign lane  = cnt_q[1:0];
    assign emit  = store & ((lane == 2'd3) | rx_last_i);
    assign off   = L2_AWIDTH_NOAL'({cnt_q[TRANS_SIZE-1:2], 2'b00});

    always_comb begin
        base = startaddr0_i;
        unique case (cur_slot)
            2'd0: base = startaddr0_i;
            2'd1: base = startaddr1_i;
            2'd2: base = startaddr2_i;
            2'd3: base = startaddr3_i;
            default: base = startaddr0_i;
        endcase
    end

    // Lane 0 starts a fresh word so unused upper bytes read as zero.
    always_comb begin
        wnext = (lane == 2'd0) ? 32'h0 : wbuf_q;
        wnext[{lane, 3'b000} +: 8] = rx_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (start_ok)
                        state_d = rx_last_i ? (rx_err_i ? DROP_END : FLUSH) : RECV;
                    else
                        state_d = rx_last_i ? DROP_END : DROP;
                end
            end
            RECV: begin
                if (acc && rx_last_i)
                    state_d = rx_err_i ? DROP_END : FLUSH;
            end
            DROP: begin
                if (acc && rx_last_i) state_d = DROP_END;
            end
            DROP_END: state_d = IDLE;
            FLUSH: begin
                if (!data_valid_o || data_ready_i) state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q       <= 2'd0;
            cnt_q        <= '0;
            wbuf_q       <= '0;
            trunc_q      <= 1'b0;
            data_o       <= '0;
            addr_o       <= '0;
            data_valid_o <= 1'b0;
            rx_pointer_o <= 2'b11;
            rx_size_o    <= '0;
            frame_irq_o  <= 1'b0;
            drop_o       <= 1'b0;
            trunc_o      <= 1'b0;
        end else begin
            frame_irq_o <= 1'b0;
            drop_o      <= 1'b0;
            trunc_o     <= 1'b0;
            if (state_q == IDLE && acc) slot_q <= slot_nxt;
            if (data_valid_o && data_ready_i) data_valid_o <= 1'b0;
            if (store) begin
                cnt_q  <= cnt_q + 1'b1;
                wbuf_q <= wnext;
            end
            if (emit) begin
                data_o       <= wnext;
                addr_o       <= base + off;
                data_valid_o <= 1'b1;
            end
            if (acc && state_q == RECV && !store) trunc_q <= 1'b1;
            if (state_q == DROP_END) begin
                drop_o  <= 1'b1;
                cnt_q   <= '0;
                trunc_q <= 1'b0;
            end
            if (state_q == COMMIT) begin
                rx_pointer_o <= slot_q;
                rx_size_o    <= cnt_q;
                frame_irq_o  <= 1'b1;
                trunc_o      <= trunc_q;
                cnt_q        <= '0;
                trunc_q      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udma_ethernet_rx_ring.sv
// Directed bench for udma_ethernet_rx_ring.
// Word stream is recorded by a monitor and compared to hand-derived frames.
module tb_udma_ethernet_rx_ring;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [11:0] startaddr0_i, startaddr1_i, startaddr2_i, startaddr3_i;
    logic [3:0]  desc_busy_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i, rx_last_i, rx_err_i;
    logic        rx_ready_o;
    logic [31:0] data_o;
    logic [11:0] addr_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic [1:0]  rx_pointer_o;
    logic [15:0] rx_size_o;
    logic        frame_irq_o, drop_o, trunc_o;

    udma_ethernet_rx_ring dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .startaddr0_i (startaddr0_i),
        .startaddr1_i (startaddr1_i),
        .startaddr2_i (startaddr2_i),
        .startaddr3_i (startaddr3_i),
        .desc_busy_i  (desc_busy_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_last_i    (rx_last_i),
        .rx_err_i     (rx_err_i),
        .rx_ready_o   (rx_ready_o),
        .data_o       (data_o),
        .addr_o       (addr_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .rx_pointer_o (rx_pointer_o),
        .rx_size_o    (rx_size_o),
        .frame_irq_o  (frame_irq_o),
        .drop_o       (drop_o),
        .trunc_o      (trunc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int irq_cnt = 0, drop_cnt = 0, trunc_cnt = 0;
    int stall_cnt = 0, viol_cnt = 0;
    int w0, i0, d0, t0;
    logic tog = 1'b0;
    logic [31:0] words[$];
    logic [11:0] addrs[$];

    always @(negedge clk_i) begin
        if (data_valid_o && data_ready_i) begin
            words.push_back(data_o);
            addrs.push_back(addr_o);
        end
        if (frame_irq_o) irq_cnt++;
        if (drop_o) drop_cnt++;
        if (trunc_o) trunc_cnt++;
        if (data_valid_o && !data_ready_i) stall_cnt++;
        if (data_valid_o && !data_ready_i && rx_ready_o) viol_cnt++;
    end

    // Period-3 ready pattern so word emission lands on a low phase.
    initial begin
        int ph = 0;
        data_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            ph = (ph + 1) % 3;
            data_ready_i = tog ? (ph != 2) : 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] slot_base(input int s);
        case (s)
            0: return 12'h100;
            1: return 12'h400;
            2: return 12'h800;
            default: return 12'hC00;
        endcase
    endfunction

    task automatic snap();
        w0 = words.size();
        i0 = irq_cnt;
        d0 = drop_cnt;
        t0 = trunc_cnt;
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last,
                             input logic err);
        int n = 0;
        logic ok;
        rx_valid_i = 1'b1;
        rx_data_i  = d;
        rx_last_i  = last;
        rx_err_i   = err;
        do begin
            @(negedge clk_i);
            ok = rx_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("byte_timeout", 32'd0, 32'd1);
        rx_valid_i = 1'b0;
        rx_last_i  = 1'b0;
        rx_err_i   = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] b0,
                              input logic err);
        for (int i = 0; i < n; i++)
            send_byte(b0 + 8'(i), i == n - 1, err && (i == n - 1));
    endtask

    task automatic wait_end();
        logic seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (irq_cnt + drop_cnt != i0 + d0) seen = 1'b1;
        end
        if (!seen) chk("end_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic check_frame(input string tag, input int nb,
                               input logic [7:0] b0, input logic [11:0] ab);
        int ns = (nb > 1536) ? 1536 : nb;
        int nw = (ns + 3) / 4;
        logic [31:0] ew;
        chk({tag, "_nwords"}, 32'(words.size() - w0), 32'(nw));
        for (int w = 0; w < nw && w0 + w < words.size(); w++) begin
            ew = '0;
            for (int j = 0; j < 4; j++)
                if (4 * w + j < ns) ew[8*j +: 8] = b0 + 8'(4 * w + j);
            chk($sformatf("%s_w%0d", tag, w), words[w0 + w], ew);
            chk($sformatf("%s_a%0d", tag, w), 32'(addrs[w0 + w]),
                32'(ab + 12'(4 * w)));
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        en_i         = 1'b1;
        startaddr0_i = 12'h100;
        startaddr1_i = 12'h400;
        startaddr2_i = 12'h800;
        startaddr3_i = 12'hC00;
        desc_busy_i  = 4'b0000;
        rx_data_i    = 8'h00;
        rx_valid_i   = 1'b0;
        rx_last_i    = 1'b0;
        rx_err_i     = 1'b0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ptr", 32'(rx_pointer_o), 32'd3);
        chk("rst_size", 32'(rx_size_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_addr", 32'(addr_o), 32'd0);
        chk("rst_valid", 32'(data_valid_o), 32'd0);
        chk("rst_pulses", 32'({frame_irq_o, drop_o, trunc_o}), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        snap();
        send_frame(64, 8'h00, 1'b0);
        wait_end();
        check_frame("t1", 64, 8'h00, 12'h100);
        chk("t1_ptr", 32'(rx_pointer_o), 32'd0);
        chk("t1_size", 32'(rx_size_o), 32'd64);
        chk("t1_irq", 32'(irq_cnt - i0), 32'd1);
        chk("t1_trunc", 32'(trunc_cnt - t0), 32'd0);
        chk("t1_drop", 32'(drop_cnt - d0), 32'd0);

        reset_dut();
        for (int f = 0; f < 5; f++) begin
            snap();
            send_frame(7, 8'hA0, 1'b0);
            wait_end();
            check_frame($sformatf("t2f%0d", f), 7, 8'hA0, slot_base(f % 4));
            chk($sformatf("t2f%0d_ptr", f), 32'(rx_pointer_o), 32'(f % 4));
            chk($sformatf("t2f%0d_size", f), 32'(rx_size_o), 32'd7);
            chk($sformatf("t2f%0d_irq", f), 32'(irq_cnt - i0), 32'd1);
        end

        desc_busy_i = 4'b0010;
        snap();
        send_frame(10, 8'h30, 1'b0);
        wait_end();
        chk("t3_words", 32'(words.size() - w0), 32'd0);
        chk("t3_drop", 32'(drop_cnt - d0), 32'd1);
        chk("t3_irq", 32'(irq_cnt - i0), 32'd0);
        chk("t3_ptr", 32'(rx_pointer_o), 32'd0);
        chk("t3_size", 32'(rx_size_o), 32'd7);
        desc_busy_i = 4'b0000;

        en_i = 1'b0;
        snap();
        send_frame(5, 8'h40, 1'b0);
        wait_end();
        chk("ten_words", 32'(words.size() - w0), 32'd0);
        chk("ten_drop", 32'(drop_cnt - d0), 32'd1);
        chk("ten_ptr", 32'(rx_pointer_o), 32'd0);
        en_i = 1'b1;

        snap();
        send_frame(20, 8'h60, 1'b1);
        wait_end();
        chk("t4_words", 32'(words.size() - w0), 32'd5);
        chk("t4_drop", 32'(drop_cnt - d0), 32'd1);
        chk("t4_irq", 32'(irq_cnt - i0), 32'd0);
        chk("t4_ptr", 32'(rx_pointer_o), 32'd0);
        chk("t4_size", 32'(rx_size_o), 32'd7);

        snap();
        send_frame(1600, 8'h00, 1'b0);
        wait_end();
        check_frame("t5", 1600, 8'h00, 12'h400);
        chk("t5_ptr", 32'(rx_pointer_o), 32'd1);
        chk("t5_size", 32'(rx_size_o), 32'd1536);
        chk("t5_trunc", 32'(trunc_cnt - t0), 32'd1);
        chk("t5_irq", 32'(irq_cnt - i0), 32'd1);
        chk("t5_drop", 32'(drop_cnt - d0), 32'd0);

        begin
            int s0 = stall_cnt;
            tog = 1'b1;
            snap();
            send_frame(12, 8'h50, 1'b0);
            wait_end();
            tog = 1'b0;
            check_frame("t6", 12, 8'h50, 12'h800);
            chk("t6_ptr", 32'(rx_pointer_o), 32'd2);
            chk("t6_size", 32'(rx_size_o), 32'd12);
            chk("t6_irq", 32'(irq_cnt - i0), 32'd1);
            chk("t6_stall_seen", 32'(stall_cnt > s0), 32'd1);
            chk("t6_ready_viol", 32'(viol_cnt), 32'd0);
        end

        for (int i = 0; i < 6; i++) send_byte(8'h70 + 8'(i), 1'b0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("t7_ptr", 32'(rx_pointer_o), 32'd3);
        chk("t7_size", 32'(rx_size_o), 32'd0);
        chk("t7_valid", 32'(data_valid_o), 32'd0);
        chk("t7_pulses", 32'({frame_irq_o, drop_o, trunc_o}), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        snap();
        send_frame(4, 8'hC0, 1'b0);
        wait_end();
        check_frame("t7b", 4, 8'hC0, 12'h100);
        chk("t7b_ptr", 32'(rx_pointer_o), 32'd0);
        chk("t7b_size", 32'(rx_size_o), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
